data_sram_resp: RTL

//  Responder for the data SRAM port driven by the execute stage; the memory side of the
//  en/we/addr/wdata protocol. Holds 2**ADDR_WIDTH 32-bit words with per-byte write enables.

---
 rtl/data_sram_resp.sv | 109 ++++++++++
 1 files changed

// File: rtl/data_sram_resp.sv
// Memory-side responder for the execute-stage data SRAM port. It provides byte-enabled
// writes, read-first capture, a fixed-latency response pipeline, saturating access counters
// and a sticky out-of-range flag.
module data_sram_resp #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        rdata_valid,
    output logic        oob_err,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0]           mem_r [DEPTH];
    logic                  valid_r [RD_LATENCY];
    logic [31:0]           data_r [RD_LATENCY];
    logic [31:0]           rd_cnt_r;
    logic [31:0]           wr_cnt_r;
    logic                  oob_err_r;

    logic [31:0]           off_s;
    logic                  in_range_s;
    logic [ADDR_WIDTH-1:0] idx_s;
    logic                  req_s;
    logic                  rd_req_s;
    logic                  wr_req_s;
    logic [31:0]           cap_word_s;

    // Address decode, request classification and read-first word capture.
    always_comb begin
        off_s      = data_sram_addr - BASE_ADDR;
        in_range_s = ((off_s >> (ADDR_WIDTH + 2)) == 32'd0);
        idx_s      = off_s[ADDR_WIDTH+1:2];
        req_s      = data_sram_en & ~reset;
        rd_req_s   = req_s & (data_sram_we == 4'b0000);
        wr_req_s   = req_s & (data_sram_we != 4'b0000);
        if (in_range_s) begin
            cap_word_s = mem_r[idx_s];
        end else begin
            cap_word_s = 32'h0000_0000;
        end
    end

    // Byte-lane writes; the array is deliberately left out of reset so contents persist.
    always_ff @(posedge clk) begin
        if (req_s && in_range_s) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_we[i]) begin
                    mem_r[idx_s][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // Response pipeline; data only advances alongside a valid, so the last stage holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < RD_LATENCY; k++) begin
                valid_r[k] <= 1'b0;
                data_r[k]  <= 32'h0000_0000;
            end
        end else begin
            valid_r[0] <= req_s;
            if (req_s) begin
                data_r[0] <= cap_word_s;
            end
            for (int k = 1; k < RD_LATENCY; k++) begin
                valid_r[k] <= valid_r[k-1];
                if (valid_r[k-1]) begin
                    data_r[k] <= data_r[k-1];
                end
            end
        end
    end

    // Saturating access counters and the sticky out-of-range flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt_r  <= 32'h0000_0000;
            wr_cnt_r  <= 32'h0000_0000;
            oob_err_r <= 1'b0;
        end else begin
            if (rd_req_s && (rd_cnt_r != 32'hFFFF_FFFF)) begin
                rd_cnt_r <= rd_cnt_r + 32'd1;
            end
            if (wr_req_s && (wr_cnt_r != 32'hFFFF_FFFF)) begin
                wr_cnt_r <= wr_cnt_r + 32'd1;
            end
            oob_err_r <= oob_err_r | (req_s & ~in_range_s);
        end
    end

    assign data_sram_rdata = data_r[RD_LATENCY-1];
    assign rdata_valid     = valid_r[RD_LATENCY-1];
    assign oob_err         = oob_err_r;
    assign rd_cnt          = rd_cnt_r;
    assign wr_cnt          = wr_cnt_r;

endmodule
